// File: rtl/hbridge_deadtime_pkg.sv
// Shared definitions for the H-bridge dead-time stage.
// Holds the per-leg state encoding, the default dead-time length and the
// helper that turns the raw arm/enable/high inputs into a leg command.
package hbridge_deadtime_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_DEAD = 2'd3
  } leg_state_t;

  localparam int DEAD_CYCLES_DEFAULT = 8;

  // Command for one leg: OFF when disarmed or not enabled, else HI/LO by the
  // high input. Only S_OFF, S_HI and S_LO are ever returned.
  function automatic leg_state_t leg_cmd(input logic arm_en, input logic en, input logic high);
    leg_state_t cmd;
    if (!arm_en || !en) begin
      cmd = S_OFF;
    end else if (high) begin
      cmd = S_HI;
    end else begin
      cmd = S_LO;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/hbridge_deadtime_leg.sv
// One H-bridge leg: state machine plus dead-time counter.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   armEn        - global arm; 0 commands OFF
//   high, en     - leg drive-high command and leg enable
//   hiGate       - registered high-side FET gate
//   loGate       - registered low-side FET gate
// Any departure from S_HI or S_LO goes through S_DEAD, which holds both gates
// off for exactly DEAD_CYCLES cycles before the command is looked at again.
module deadtime_leg
  import hbridge_deadtime_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic armEn,
  input  logic high,
  input  logic en,
  output logic hiGate,
  output logic loGate
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  leg_state_t    state;
  leg_state_t    state_next;
  leg_state_t    cmd;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign cmd = leg_cmd(armEn, en, high);

  // Next-state and counter logic for the leg.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_OFF: begin
        state_next = cmd;
        cnt_next   = CNT_ZERO;
      end
      S_HI: begin
        if (cmd == S_HI) begin
          state_next = S_HI;
        end else begin
          state_next = S_DEAD;
          cnt_next   = CNT_LOAD;
        end
      end
      S_LO: begin
        if (cmd == S_LO) begin
          state_next = S_LO;
        end else begin
          state_next = S_DEAD;
          cnt_next   = CNT_LOAD;
        end
      end
      S_DEAD: begin
        // The command is only honoured on the last dead cycle, so a flip-back
        // mid dead time cannot shorten it.
        if (cnt == CNT_ZERO) begin
          state_next = cmd;
        end else begin
          state_next = S_DEAD;
          cnt_next   = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = S_OFF;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and gate registers; gates are decoded from the next state
  // so they line up with the registered state without a combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_OFF;
      cnt    <= CNT_ZERO;
      hiGate <= 1'b0;
      loGate <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      hiGate <= (state_next == S_HI);
      loGate <= (state_next == S_LO);
    end
  end

endmodule

// File: rtl/hbridge_deadtime.sv
// Gate-drive conditioning between the tone generator and the H-bridge drivers.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   armEn                      - global arm; 0 turns every leg off via dead time
//   leftHigh/leftEn            - per-track left leg command and enable
//   rightHigh/rightEn          - per-track right leg command and enable
//   leftHiGate/leftLoGate      - per-track left leg high/low FET gates
//   rightHiGate/rightLoGate    - per-track right leg high/low FET gates
// Every leg is an independent deadtime_leg instance.
module hbridge_deadtime
  import hbridge_deadtime_pkg::*;
#(
  parameter int NUM_TRACKS  = 4,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  armEn,
  input  logic [NUM_TRACKS-1:0] leftHigh,
  input  logic [NUM_TRACKS-1:0] leftEn,
  input  logic [NUM_TRACKS-1:0] rightHigh,
  input  logic [NUM_TRACKS-1:0] rightEn,
  output logic [NUM_TRACKS-1:0] leftHiGate,
  output logic [NUM_TRACKS-1:0] leftLoGate,
  output logic [NUM_TRACKS-1:0] rightHiGate,
  output logic [NUM_TRACKS-1:0] rightLoGate
);

  deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_left [NUM_TRACKS-1:0] (
    .clk    (clk),
    .reset  (reset),
    .armEn  (armEn),
    .high   (leftHigh),
    .en     (leftEn),
    .hiGate (leftHiGate),
    .loGate (leftLoGate)
  );

  deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_right [NUM_TRACKS-1:0] (
    .clk    (clk),
    .reset  (reset),
    .armEn  (armEn),
    .high   (rightHigh),
    .en     (rightEn),
    .hiGate (rightHiGate),
    .loGate (rightLoGate)
  );

endmodule
